// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//   AXI4 responder word memory serving the core's instruction and data
//   masters. Read (AR/R) and write (AW/W/B) engines run independently over
//   one shared single-clock RAM of 2**C_MEM_DEPTH_LOG2 32-bit words.
//   Bursts are always INCR with 4-byte beats. The word index is
//   addr[C_MEM_DEPTH_LOG2+1:2]: upper address bits alias, and the index
//   wraps from the last word to word 0 inside a burst.
//
//   Configuration macro: AXI_MEM_WRITE_EN
//     defined   : write engine present (AW -> W beats -> B response).
//     undefined : ROM. AWREADY/WREADY/BVALID are held 0 and no write port
//                 exists; the read engine is unchanged.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   S_AXI_AR{ID,ADDR,LEN,VALID}   read address channel in, ARREADY out
//   S_AXI_R{ID,DATA,RESP,LAST,VALID} read data channel out, RREADY in
//   S_AXI_AW{ID,ADDR,LEN,VALID}   write address channel in, AWREADY out
//   S_AXI_W{DATA,STRB,VALID}      write data channel in, WREADY out
//   S_AXI_B{ID,RESP,VALID}        write response channel out, BREADY in
// ---------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH_LOG2   = 12
) (
  input  logic                          CLK,
  input  logic                          RST,
  // read address
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  // read data
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  // write address
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  // write data
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  // write response
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY
);

  localparam int unsigned ID_W   = C_S_AXI_ID_WIDTH;
  localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IDX_W  = C_MEM_DEPTH_LOG2;
  localparam int unsigned DEPTH  = 32'd1 << IDX_W;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  // Shared word array; contents are never reset.
  logic [31:0] mem [0:DEPTH-1];

  // -------------------------------------------------------------------------
  // Read engine
  // -------------------------------------------------------------------------
  logic [0:0]       r_state,   r_state_d;
  logic [IDX_W-1:0] r_idx,     r_idx_d;     // index of the next beat to fetch
  logic [7:0]       r_cnt,     r_cnt_d;     // beats remaining after the one shown
  logic             arready_q, arready_d;
  logic             rvalid_q,  rvalid_d;
  logic             rlast_q,   rlast_d;
  logic [ID_W-1:0]  rid_q,     rid_d;
  logic [31:0]      rdata_q;
  logic             rd_en_c;
  logic [IDX_W-1:0] rd_idx_c;

  // Next-state: fetch a word on the AR handshake and on every R handshake
  // that is not the last, so beats stream without bubbles.
  always_comb begin
    r_state_d = r_state;
    r_idx_d   = r_idx;
    r_cnt_d   = r_cnt;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rd_en_c   = 1'b0;
    rd_idx_c  = r_idx;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && S_AXI_ARVALID) begin
          rd_en_c   = 1'b1;
          rd_idx_c  = S_AXI_ARADDR[IDX_W+1:2];
          r_idx_d   = S_AXI_ARADDR[IDX_W+1:2] + IDX_W'(1);
          r_cnt_d   = S_AXI_ARLEN;
          rid_d     = S_AXI_ARID;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (rvalid_q && S_AXI_RREADY) begin
          if (r_cnt == 8'd0) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rd_en_c  = 1'b1;
            rd_idx_c = r_idx;
            r_idx_d  = r_idx + IDX_W'(1);
            r_cnt_d  = r_cnt - 8'd1;
            rlast_d  = (r_cnt == 8'd1);
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Read state and output registers; RDATA is the synchronous RAM read and
  // only changes on a fetch, which holds it stable through R stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      r_state   <= r_state_d;
      r_idx     <= r_idx_d;
      r_cnt     <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      if (rd_en_c) begin
        rdata_q <= mem[rd_idx_c];
      end
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  // Address bits outside the word index carry no information here.
  logic unused_rd_addr;
  assign unused_rd_addr = &{1'b0, S_AXI_ARADDR[1:0], S_AXI_ARADDR[ADDR_W-1:IDX_W+2]};

`ifdef AXI_MEM_WRITE_EN
  // -------------------------------------------------------------------------
  // Write engine
  // -------------------------------------------------------------------------
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]       w_state,   w_state_d;
  logic [IDX_W-1:0] w_idx,     w_idx_d;
  logic [7:0]       w_cnt,     w_cnt_d;    // beats remaining after the current one
  logic             awready_q, awready_d;
  logic             wready_q,  wready_d;
  logic             bvalid_q,  bvalid_d;
  logic [ID_W-1:0]  bid_q,     bid_d;
  logic             wr_en_c;

  // Next-state: AW opens the data phase, beat AWLEN+1 closes it into B.
  always_comb begin
    w_state_d = w_state;
    w_idx_d   = w_idx;
    w_cnt_d   = w_cnt;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    wr_en_c   = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && S_AXI_AWVALID) begin
          w_idx_d   = S_AXI_AWADDR[IDX_W+1:2];
          w_cnt_d   = S_AXI_AWLEN;
          bid_d     = S_AXI_AWID;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wready_q && S_AXI_WVALID) begin
          wr_en_c = 1'b1;
          w_idx_d = w_idx + IDX_W'(1);
          if (w_cnt == 8'd0) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Write state and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state   <= W_IDLE;
      w_idx     <= '0;
      w_cnt     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      w_state   <= w_state_d;
      w_idx     <= w_idx_d;
      w_cnt     <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
    end
  end

  // Byte-enabled RAM write port; a same-cycle read of this word sees old data.
  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (S_AXI_WSTRB[i]) begin
          mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = 2'b00;

  logic unused_wr_addr;
  assign unused_wr_addr = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_AWADDR[ADDR_W-1:IDX_W+2]};
`else
  // ROM build: the write channels never handshake.
  assign S_AXI_AWREADY = 1'b0;
  assign S_AXI_WREADY  = 1'b0;
  assign S_AXI_BVALID  = 1'b0;
  assign S_AXI_BID     = '0;
  assign S_AXI_BRESP   = 2'b00;

  logic unused_wr_inputs;
  assign unused_wr_inputs = &{1'b0, S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
                              S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY};
`endif

endmodule
